// File: rtl/qm_sweep_driver.sv
// qm_sweep_driver: exhaustive stimulus-and-capture wrapper for an N_IN-input
// combinational function. Walks every input vector once per sweep, samples
// the function response each cycle and accumulates a ones-count, the first
// asserting vector and (optionally) a 16-bit MISR signature.
//
// Optional feature macro: QM_SWEEP_MISR_EN
//   defined   -> signature is a 16-bit MISR over the dut_out stream
//   undefined -> signature is constant 16'h0000, no MISR flops
module qm_sweep_driver #(
   parameter int N_IN  = 11,
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [N_IN-1:0]  dut_in,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] ones_cnt,
   output logic             hit_valid,
   output logic [N_IN-1:0]  first_hit,
   output logic [15:0]      signature
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             launch;
   logic             last_vec;
   logic [N_IN-1:0]  idx_p0;

   // Holding increment: the counter is sized so it cannot overflow, but a
   // mis-parameterised instance saturates instead of silently wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end
      return v + 1'b1;
   endfunction

   // The index register is 0 outside SWEEP (reset, launch and the final wrap
   // all leave it at 0), so it drives the function inputs directly.
   assign dut_in   = idx_p0;
   assign last_vec = (idx_p0 == {N_IN{1'b1}});

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode, sweep launch and status outputs
   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               launch    = 1'b1;
               state_nxt = SWEEP;
            end
         end
         SWEEP: begin
            busy = 1'b1;
            if (last_vec) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               launch    = 1'b1;
               state_nxt = SWEEP;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Stage p0: index walk and response accumulation (dut_out settles within
   // the cycle, so the sample at each edge belongs to the current index)
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_p0    <= '0;
         ones_cnt  <= '0;
         hit_valid <= 1'b0;
         first_hit <= '0;
      end else if (launch) begin
         idx_p0    <= '0;
         ones_cnt  <= '0;
         hit_valid <= 1'b0;
         first_hit <= '0;
      end else if (state == SWEEP) begin
         idx_p0 <= idx_p0 + 1'b1;
         if (dut_out) begin
            ones_cnt <= sat_inc(ones_cnt);
            if (!hit_valid) begin
               hit_valid <= 1'b1;
               first_hit <= idx_p0;
            end
         end
      end
   end

`ifdef QM_SWEEP_MISR_EN
   logic [15:0] sig_p0;

   function automatic logic misr_fb(input logic [15:0] s, input logic d);
      return s[15] ^ s[13] ^ s[12] ^ s[10] ^ d;
   endfunction

   // MISR: seeded on launch, shifts once per swept vector, holds otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_p0 <= 16'h0000;
      end else if (launch) begin
         sig_p0 <= 16'hFFFF;
      end else if (state == SWEEP) begin
         sig_p0 <= {sig_p0[14:0], misr_fb(sig_p0, dut_out)};
      end
   end

   assign signature = sig_p0;
`else
   assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_qm_sweep_driver.sv
// Self-checking bench for qm_sweep_driver. The function under test is a
// response table indexed by dut_in; the reference model aggregates that
// table directly (count, lowest asserting vector, MISR).
module tb_qm_sweep_driver;

   localparam int N_IN  = 11;
   localparam int CNT_W = 12;
   localparam int NVEC  = 2048;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [N_IN-1:0]  dut_in;
   logic             dut_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] ones_cnt;
   logic             hit_valid;
   logic [N_IN-1:0]  first_hit;
   logic [15:0]      signature;

   logic             tbl [0:NVEC-1];

   int               total = 0;
   int               bad = 0;

   int               exp_cnt;
   logic             exp_hit;
   logic [N_IN-1:0]  exp_first;
   logic [15:0]      exp_sig;
   logic [15:0]      exp_seed;

   qm_sweep_driver #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dut_in    (dut_in),
      .dut_out   (dut_out),
      .busy      (busy),
      .done      (done),
      .ones_cnt  (ones_cnt),
      .hit_valid (hit_valid),
      .first_hit (first_hit),
      .signature (signature)
   );

   always #5 clk = ~clk;

   assign dut_out = tbl[dut_in];

   // Sample minimised SOP over a..k (a = bit 10, k = bit 0)
   function automatic logic sop(input logic [10:0] v);
      logic a, b, c, d, e, f, g, h, i, j, k;
      {a, b, c, d, e, f, g, h, i, j, k} = v;
      return (a & ~b & c & h) | (~d & e & f & ~g & j) |
             (h & i & j & k & ~a & b) | (b & ~c & ~e & g & ~k & d);
   endfunction

   // mode: 0 all-zero, 1 all-one, 2 single 11'h5A3, 3 SOP, 4 random
   task automatic fill_table(input int mode);
      for (int v = 0; v < NVEC; v++) begin
         case (mode)
            0: tbl[v] = 1'b0;
            1: tbl[v] = 1'b1;
            2: tbl[v] = (v == 'h5A3);
            3: tbl[v] = sop(11'(v));
            default: tbl[v] = ($urandom_range(0, 15) == 0);
         endcase
      end
   endtask

   task automatic ref_model;
      logic [15:0] s;
      s = 16'hFFFF;
      exp_cnt = 0;
      exp_hit = 1'b0;
      exp_first = '0;
      for (int v = 0; v < NVEC; v++) begin
         if (tbl[v]) begin
            exp_cnt++;
            if (!exp_hit) begin
               exp_hit = 1'b1;
               exp_first = 11'(v);
            end
         end
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ tbl[v]};
      end
`ifdef QM_SWEEP_MISR_EN
      exp_sig  = s;
      exp_seed = 16'hFFFF;
`else
      exp_sig  = 16'h0000;
      exp_seed = 16'h0000;
`endif
   endtask

   // One full sweep from the current cycle. ign_at >= 0 pulses start at that
   // index (must be ignored). idle_after = 0 leaves the bench in the DONE
   // cycle so a following call exercises a back-to-back start.
   task automatic run_sweep(input string tag, input int ign_at, input bit idle_after);
      int walk_err;
      walk_err = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || ones_cnt !== '0 || hit_valid !== 1'b0 || first_hit !== '0) begin
         bad++;
         $display("FAIL %s launch: busy=%b done=%b cnt=%0d hv=%b fh=%0h want busy=1 done=0 cleared",
                  tag, busy, done, ones_cnt, hit_valid, first_hit);
      end
      total++;
      if (signature !== exp_seed) begin
         bad++;
         $display("FAIL %s seed: got %h want %h", tag, signature, exp_seed);
      end
      for (int i = 0; i < NVEC; i++) begin
         if (dut_in !== 11'(i) || busy !== 1'b1 || done !== 1'b0) walk_err++;
         if (i == ign_at) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      total++;
      if (walk_err != 0) begin
         bad++;
         $display("FAIL %s walk: %0d bad cycles want 0", tag, walk_err);
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || dut_in !== '0) begin
         bad++;
         $display("FAIL %s done_cycle: done=%b busy=%b dut_in=%0d want 1 0 0", tag, done, busy, dut_in);
      end
      total++;
      if (ones_cnt !== 12'(exp_cnt)) begin
         bad++;
         $display("FAIL %s ones_cnt: got %0d want %0d", tag, ones_cnt, exp_cnt);
      end
      total++;
      if (hit_valid !== exp_hit || first_hit !== exp_first) begin
         bad++;
         $display("FAIL %s first_hit: got hv=%b fh=%h want hv=%b fh=%h",
                  tag, hit_valid, first_hit, exp_hit, exp_first);
      end
      total++;
      if (signature !== exp_sig) begin
         bad++;
         $display("FAIL %s signature: got %h want %h", tag, signature, exp_sig);
      end
      if (idle_after) begin
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || ones_cnt !== 12'(exp_cnt) || signature !== exp_sig) begin
            bad++;
            $display("FAIL %s hold: done=%b busy=%b cnt=%0d sig=%h want 0 0 %0d %h",
                     tag, done, busy, ones_cnt, signature, exp_cnt, exp_sig);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (dut_in !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: dut_in=%0d busy=%b done=%b want 0", dut_in, busy, done);
      end
      total++;
      if (ones_cnt !== '0 || hit_valid !== 1'b0 || first_hit !== '0 || signature !== 16'h0000) begin
         bad++;
         $display("FAIL reset_results: cnt=%0d hv=%b fh=%h sig=%h want 0", ones_cnt, hit_valid, first_hit, signature);
      end
      // rst and start together: rst wins
      start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_vs_start: busy=%b want 0", busy);
      end
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || dut_in !== '0) begin
         bad++;
         $display("FAIL idle_hold: busy=%b dut_in=%0d want 0 0", busy, dut_in);
      end
   endtask

   task automatic test_patterns;
      fill_table(0); ref_model(); run_sweep("zero", -1, 1'b1);
      fill_table(1); ref_model(); run_sweep("ones", -1, 1'b1);
      fill_table(2); ref_model(); run_sweep("single", -1, 1'b1);
      fill_table(4); ref_model(); run_sweep("random", -1, 1'b1);
   endtask

   task automatic test_sop_repeat;
      logic [CNT_W-1:0] c1;
      logic [N_IN-1:0]  f1;
      logic [15:0]      s1;
      fill_table(3); ref_model();
      run_sweep("sop1", -1, 1'b1);
      c1 = ones_cnt; f1 = first_hit; s1 = signature;
      run_sweep("sop2", -1, 1'b1);
      total++;
      if (ones_cnt !== c1 || first_hit !== f1 || signature !== s1) begin
         bad++;
         $display("FAIL sop_repeat: got %0d %h %h want %0d %h %h", ones_cnt, first_hit, signature, c1, f1, s1);
      end
   endtask

   task automatic test_mid_reset;
      int done_seen;
      fill_table(4); ref_model();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (1000) begin
         @(posedge clk); #1;
      end
      total++;
      if (dut_in !== 11'd1000) begin
         bad++;
         $display("FAIL midrst_index: got %0d want 1000", dut_in);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || dut_in !== '0 || ones_cnt !== '0 || hit_valid !== 1'b0 ||
          first_hit !== '0 || signature !== 16'h0000 || done !== 1'b0) begin
         bad++;
         $display("FAIL midrst_clear: busy=%b in=%0d cnt=%0d hv=%b fh=%h sig=%h done=%b want all 0",
                  busy, dut_in, ones_cnt, hit_valid, first_hit, signature, done);
      end
      done_seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      end
      total++;
      if (done_seen != 0) begin
         bad++;
         $display("FAIL midrst_quiet: %0d active cycles want 0", done_seen);
      end
      run_sweep("after_rst", -1, 1'b1);
   endtask

   task automatic test_start_ignored;
      fill_table(4); ref_model();
      run_sweep("ign500", 500, 1'b1);
   endtask

   task automatic test_back_to_back;
      fill_table(3); ref_model();
      run_sweep("b2b_a", -1, 1'b0);
      fill_table(4); ref_model();
      run_sweep("b2b_b", -1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_sop_repeat();
      test_mid_reset();
      test_start_ignored();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
